// File: rtl/frame_collision_unit.sv
// ---------------------------------------------------------------------------
// frame_collision_unit
//
// Per-frame collision detector for the VGA game. On every pixel clock the
// player's drawing request is compared against NUM_CH object drawing
// requests. A channel counts as hit once its overlap reaches MIN_OVERLAP
// pixels within one frame. The first pixel that makes a channel qualify
// produces a one-cycle hit pulse. At each startOfFrame a stable summary of
// the frame that just ended is published and held for the whole next frame.
//
// Ports
//   clk                     in   1       system clock
//   resetN                  in   1       asynchronous active-low reset
//   startOfFrame            in   1       one-cycle pulse at the start of each frame
//   drawing_request_player  in   1       player pixel is opaque this cycle
//   drawing_request_obj     in   NUM_CH  per-channel object pixel is opaque
//   chan_enable             in   NUM_CH  0 = channel ignored and cleared
//   hit_pulse               out  NUM_CH  one-cycle pulse when a channel first hits
//   frame_hits              out  NUM_CH  channels hit during the previous frame
//   hit_count               out  POP_W   popcount of frame_hits
//   first_hit_valid         out  1       a hit occurred in the previous frame
//   first_hit_idx           out  IDX_W   earliest-hit channel of the previous frame
//   frame_valid             out  1       a complete frame has been summarised
//
// All outputs are registered; there is no combinational input-to-output path.
// The FSM state is held in the named signal 'state' (SYNC / ACCUM).
// ---------------------------------------------------------------------------
module frame_collision_unit #(
   parameter int NUM_CH      = 5,
   parameter int MIN_OVERLAP = 4,
   localparam int CNT_W = $clog2(MIN_OVERLAP + 1),
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int POP_W = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              startOfFrame,
   input  logic              drawing_request_player,
   input  logic [NUM_CH-1:0] drawing_request_obj,
   input  logic [NUM_CH-1:0] chan_enable,
   output logic [NUM_CH-1:0] hit_pulse,
   output logic [NUM_CH-1:0] frame_hits,
   output logic [POP_W-1:0]  hit_count,
   output logic              first_hit_valid,
   output logic [IDX_W-1:0]  first_hit_idx,
   output logic              frame_valid
);

   typedef enum logic {
      SYNC  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MIN_OVERLAP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_OVERLAP - 1);

   state_t state, next_state;
   logic   publish;   // summary is captured at this edge
   logic   run;       // accumulators take part in this cycle

   logic [CNT_W-1:0]  cnt     [NUM_CH];
   logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
   logic [NUM_CH-1:0] hit, hit_nxt, hit_set, overlap;
   logic [CNT_W-1:0]  base_cnt;
   logic              base_hit;

   logic              rec_valid, rec_valid_nxt;
   logic [IDX_W-1:0]  rec_idx, rec_idx_nxt, set_idx;
   logic [POP_W-1:0]  hit_pop;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= SYNC;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      publish    = 1'b0;
      run        = 1'b0;
      case (state)
         SYNC: begin
            // The startOfFrame cycle already belongs to the first real frame.
            if (startOfFrame) begin
               next_state = ACCUM;
               run        = 1'b1;
            end
         end
         ACCUM: begin
            run = 1'b1;
            if (startOfFrame) publish = 1'b1;
         end
         default: next_state = SYNC;
      endcase
   end

   // ------------------------------------------------ per-channel counters
   // On startOfFrame the counters restart from zero before this cycle's
   // overlap is applied, so a pixel in that cycle counts for the new frame.
   always_comb begin
      overlap  = {NUM_CH{drawing_request_player}} & drawing_request_obj & chan_enable;
      base_cnt = '0;
      base_hit = 1'b0;
      hit_nxt  = '0;
      hit_set  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         base_cnt   = startOfFrame ? '0 : cnt[i];
         base_hit   = startOfFrame ? 1'b0 : hit[i];
         cnt_nxt[i] = base_cnt;
         hit_nxt[i] = base_hit;
         if (!run || !chan_enable[i]) begin
            cnt_nxt[i] = '0;
            hit_nxt[i] = 1'b0;
         end else if (overlap[i] && (base_cnt < CNT_MAX)) begin
            // Saturating count: once at CNT_MAX no further pulse can occur.
            cnt_nxt[i] = base_cnt + 1'b1;
            if (base_cnt == CNT_LAST) begin
               hit_nxt[i] = 1'b1;
               hit_set[i] = 1'b1;
            end
         end
      end
   end

   // --------------------------------------- first-hit record and popcount
   always_comb begin
      // Descending scan so the lowest qualifying index ends up selected.
      set_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hit_set[i]) set_idx = IDX_W'(i);
      end

      rec_valid_nxt = startOfFrame ? 1'b0 : rec_valid;
      rec_idx_nxt   = startOfFrame ? '0 : rec_idx;
      if (!run) begin
         rec_valid_nxt = 1'b0;
         rec_idx_nxt   = '0;
      end else if (!rec_valid_nxt && (|hit_set)) begin
         rec_valid_nxt = 1'b1;
         rec_idx_nxt   = set_idx;
      end

      hit_pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit_pop = hit_pop + POP_W'(hit[i]);
      end
   end

   // ---------------------------------------------------------- registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         hit             <= '0;
         hit_pulse       <= '0;
         rec_valid       <= 1'b0;
         rec_idx         <= '0;
         frame_hits      <= '0;
         hit_count       <= '0;
         first_hit_valid <= 1'b0;
         first_hit_idx   <= '0;
         frame_valid     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
         hit       <= hit_nxt;
         hit_pulse <= hit_set;
         rec_valid <= rec_valid_nxt;
         rec_idx   <= rec_idx_nxt;
         // Publish uses the pre-clear state of the frame that just ended.
         if (publish) begin
            frame_hits      <= hit;
            hit_count       <= hit_pop;
            first_hit_valid <= rec_valid;
            first_hit_idx   <= rec_idx;
            frame_valid     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_collision_unit.sv
// ---------------------------------------------------------------------------
// tb_frame_collision_unit
//
// Directed bench for frame_collision_unit with default parameters
// (NUM_CH=5, MIN_OVERLAP=4). Inputs change #1 after a rising edge and are
// held across the next one; outputs are observed #1 after that edge.
// ---------------------------------------------------------------------------
module tb_frame_collision_unit;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame;
   logic       drawing_request_player;
   logic [4:0] drawing_request_obj;
   logic [4:0] chan_enable;
   logic [4:0] hit_pulse;
   logic [4:0] frame_hits;
   logic [2:0] hit_count;
   logic       first_hit_valid;
   logic [2:0] first_hit_idx;
   logic       frame_valid;

   int tests = 0;
   int fails = 0;

   frame_collision_unit dut (
      .clk                    (clk),
      .resetN                 (resetN),
      .startOfFrame           (startOfFrame),
      .drawing_request_player (drawing_request_player),
      .drawing_request_obj    (drawing_request_obj),
      .chan_enable            (chan_enable),
      .hit_pulse              (hit_pulse),
      .frame_hits             (frame_hits),
      .hit_count              (hit_count),
      .first_hit_valid        (first_hit_valid),
      .first_hit_idx          (first_hit_idx),
      .frame_valid            (frame_valid)
   );

   always #5 clk = ~clk;

   // One pixel clock: apply inputs, let one rising edge consume them.
   task automatic cyc(input logic sof, input logic pl, input logic [4:0] obj);
      startOfFrame           = sof;
      drawing_request_player = pl;
      drawing_request_obj    = obj;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      chan_enable = 5'b11111;
      startOfFrame = 1'b0;
      drawing_request_player = 1'b0;
      drawing_request_obj = 5'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++;
      if ({hit_pulse, frame_hits, hit_count, first_hit_valid, first_hit_idx, frame_valid} !== 20'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {hit_pulse, frame_hits, hit_count, first_hit_valid, first_hit_idx, frame_valid});
      end
      resetN = 1'b1;
      cyc(1'b1, 1'b0, 5'b0);   // first startOfFrame: no publish
      tests++;
      if (frame_valid !== 1'b0 || frame_hits !== 5'b0 || hit_count !== 3'd0) begin
         fails++;
         $display("FAIL first_sof_no_publish: frame_valid=%b frame_hits=%b hit_count=%0d expected 0/0/0",
                  frame_valid, frame_hits, hit_count);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'b0);
      cyc(1'b1, 1'b0, 5'b0);   // second startOfFrame: empty frame published
      tests++;
      if (frame_valid !== 1'b1 || frame_hits !== 5'b0 || hit_count !== 3'd0 || first_hit_valid !== 1'b0) begin
         fails++;
         $display("FAIL empty_publish: frame_valid=%b frame_hits=%b hit_count=%0d fhv=%b expected 1/00000/0/0",
                  frame_valid, frame_hits, hit_count, first_hit_valid);
      end
   endtask

   task automatic test_threshold();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 5'b00100);
         tests++;
         if (hit_pulse !== 5'b0) begin
            fails++;
            $display("FAIL below_threshold_pulse[%0d]: got %b expected 00000", i, hit_pulse);
         end
      end
      // Non-overlapping pixels must not count.
      cyc(1'b0, 1'b0, 5'b00100);
      cyc(1'b0, 1'b1, 5'b00000);
      tests++;
      if (hit_pulse !== 5'b0) begin
         fails++;
         $display("FAIL no_overlap_pulse: got %b expected 00000", hit_pulse);
      end
      cyc(1'b0, 1'b1, 5'b00100);
      tests++;
      if (hit_pulse !== 5'b00100) begin
         fails++;
         $display("FAIL threshold_pulse: got %b expected 00100", hit_pulse);
      end
      cyc(1'b0, 1'b0, 5'b0);
      tests++;
      if (hit_pulse !== 5'b0) begin
         fails++;
         $display("FAIL pulse_one_cycle: got %b expected 00000", hit_pulse);
      end
      cyc(1'b1, 1'b0, 5'b0);
      tests++;
      if (frame_hits !== 5'b00100 || hit_count !== 3'd1 || first_hit_valid !== 1'b1 || first_hit_idx !== 3'd2) begin
         fails++;
         $display("FAIL threshold_publish: hits=%b cnt=%0d fhv=%b idx=%0d expected 00100/1/1/2",
                  frame_hits, hit_count, first_hit_valid, first_hit_idx);
      end
   endtask

   task automatic test_same_cycle();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 5'b01010);
         if (i == 0) begin
            tests++;
            if (frame_hits !== 5'b00100 || hit_count !== 3'd1) begin
               fails++;
               $display("FAIL summary_held: hits=%b cnt=%0d expected 00100/1", frame_hits, hit_count);
            end
         end
      end
      tests++;
      if (hit_pulse !== 5'b01010) begin
         fails++;
         $display("FAIL dual_pulse: got %b expected 01010", hit_pulse);
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 5'b00001);
      tests++;
      if (hit_pulse !== 5'b00001) begin
         fails++;
         $display("FAIL ch0_pulse: got %b expected 00001", hit_pulse);
      end
      cyc(1'b1, 1'b0, 5'b0);
      tests++;
      if (frame_hits !== 5'b01011 || hit_count !== 3'd3 || first_hit_valid !== 1'b1 || first_hit_idx !== 3'd1) begin
         fails++;
         $display("FAIL same_cycle_publish: hits=%b cnt=%0d fhv=%b idx=%0d expected 01011/3/1/1",
                  frame_hits, hit_count, first_hit_valid, first_hit_idx);
      end
   endtask

   task automatic test_saturate();
      int pulses = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b1, 5'b10000);
         if (hit_pulse[4]) pulses++;
      end
      cyc(1'b0, 1'b0, 5'b0);
      if (hit_pulse[4]) pulses++;
      tests++;
      if (pulses != 1) begin
         fails++;
         $display("FAIL saturate_pulses: got %0d expected 1", pulses);
      end
      tests++;
      if (dut.cnt[4] !== 3'd4) begin
         fails++;
         $display("FAIL saturate_count: got %0d expected 4", dut.cnt[4]);
      end
      cyc(1'b1, 1'b0, 5'b0);
      tests++;
      if (frame_hits !== 5'b10000 || hit_count !== 3'd1 || first_hit_idx !== 3'd4) begin
         fails++;
         $display("FAIL saturate_publish: hits=%b cnt=%0d idx=%0d expected 10000/1/4",
                  frame_hits, hit_count, first_hit_idx);
      end
   endtask

   task automatic test_enable_drop();
      int pulses = 0;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'b00001);
      chan_enable = 5'b11110;
      cyc(1'b0, 1'b0, 5'b0);
      chan_enable = 5'b11111;
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, 5'b00001);
         if (hit_pulse[0]) pulses++;
      end
      cyc(1'b0, 1'b0, 5'b0);
      if (hit_pulse[0]) pulses++;
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL enable_drop_pulse: got %0d pulses expected 0", pulses);
      end
      cyc(1'b1, 1'b0, 5'b0);
      tests++;
      if (frame_hits !== 5'b0 || hit_count !== 3'd0 || first_hit_valid !== 1'b0) begin
         fails++;
         $display("FAIL enable_drop_publish: hits=%b cnt=%0d fhv=%b expected 00000/0/0",
                  frame_hits, hit_count, first_hit_valid);
      end
   endtask

   task automatic test_sof_overlap();
      // Three pixels in the old frame, the fourth arrives with startOfFrame.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'b00100);
      cyc(1'b1, 1'b1, 5'b00100);
      tests++;
      if (hit_pulse !== 5'b0 || frame_hits !== 5'b0) begin
         fails++;
         $display("FAIL sof_overlap_publish: pulse=%b hits=%b expected 00000/00000", hit_pulse, frame_hits);
      end
      cyc(1'b0, 1'b1, 5'b00100);
      cyc(1'b0, 1'b1, 5'b00100);
      tests++;
      if (hit_pulse !== 5'b0) begin
         fails++;
         $display("FAIL sof_overlap_early: got %b expected 00000", hit_pulse);
      end
      cyc(1'b0, 1'b1, 5'b00100);
      tests++;
      if (hit_pulse !== 5'b00100) begin
         fails++;
         $display("FAIL sof_overlap_counted: got %b expected 00100", hit_pulse);
      end
      cyc(1'b1, 1'b0, 5'b0);
      tests++;
      if (frame_hits !== 5'b00100 || hit_count !== 3'd1 || first_hit_idx !== 3'd2) begin
         fails++;
         $display("FAIL sof_overlap_frame: hits=%b cnt=%0d idx=%0d expected 00100/1/2",
                  frame_hits, hit_count, first_hit_idx);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 5'b00010);
      tests++;
      if (hit_pulse !== 5'b00010) begin
         fails++;
         $display("FAIL pre_reset_pulse: got %b expected 00010", hit_pulse);
      end
      cyc(1'b1, 1'b0, 5'b0);   // publish ch1 so outputs are non-zero
      cyc(1'b0, 1'b0, 5'b0);
      #2;
      resetN = 1'b0;
      #1;
      tests++;
      if ({hit_pulse, frame_hits, hit_count, first_hit_valid, first_hit_idx, frame_valid} !== 20'd0) begin
         fails++;
         $display("FAIL async_reset_outputs: got %h expected 0",
                  {hit_pulse, frame_hits, hit_count, first_hit_valid, first_hit_idx, frame_valid});
      end
      @(posedge clk); #1;
      resetN = 1'b1;
      cyc(1'b1, 1'b0, 5'b0);
      tests++;
      if (frame_valid !== 1'b0 || frame_hits !== 5'b0) begin
         fails++;
         $display("FAIL post_reset_sof: frame_valid=%b hits=%b expected 0/00000", frame_valid, frame_hits);
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 5'b01000);
      cyc(1'b1, 1'b0, 5'b0);
      tests++;
      if (frame_valid !== 1'b1 || frame_hits !== 5'b01000 || hit_count !== 3'd1 ||
          first_hit_valid !== 1'b1 || first_hit_idx !== 3'd3) begin
         fails++;
         $display("FAIL fresh_frame: fv=%b hits=%b cnt=%0d fhv=%b idx=%0d expected 1/01000/1/1/3",
                  frame_valid, frame_hits, hit_count, first_hit_valid, first_hit_idx);
      end
   endtask

   initial begin
      test_reset();
      test_threshold();
      test_same_cycle();
      test_saturate();
      test_enable_drop();
      test_sof_overlap();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
